// File: rtl/qduc_ctrl.sv
// Configuration sequencer for the quadrature DUC: shadows one request, commits it on a
// CIC stage-1 rate boundary (or on timeout), and runs flush/mute around disruptive changes.
module qduc_ctrl #(
  parameter int FSZ           = 31,
  parameter int CNT_W         = 16,
  parameter int FLUSH_CYCLES  = 128,
  parameter int SETTLE_CYCLES = 256,
  parameter int TIMEOUT       = 1024
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [FSZ-1:0] cfg_freq,
  input  logic           cfg_dir,
  input  logic           cfg_ns_en,
  input  logic           cfg_iq_swap,
  input  logic           cfg_tuner_byp,
  input  logic           rate_strobe,
  output logic [FSZ-1:0] lo_freq,
  output logic           lo_dir,
  output logic           lo_ns_en,
  output logic           iq_swap,
  output logic           tuner_byp,
  output logic           dp_reset,
  output logic           mute,
  output logic           busy,
  output logic           timeout_flag,
  output logic [7:0]     apply_cnt
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_BOUND = 2'd1,
    S_FLUSH      = 2'd2,
    S_SETTLE     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] FLUSH_LAST   = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic [FSZ-1:0]   sh_freq;
  logic             sh_dir;
  logic             sh_ns_en;
  logic             sh_iq_swap;
  logic             sh_tuner_byp;

  logic             capture;
  logic             commit;
  logic             forced;
  logic             disruptive;

  // Handshake: a request transfers on a rising edge where cfg_valid && cfg_ready are both
  // high; cfg_ready is high only in IDLE, so at most one request is ever in flight and the
  // cfg_* bus is don't-care whenever cfg_ready is low.
  assign disruptive = (sh_tuner_byp != tuner_byp) || (sh_dir != lo_dir);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    commit   = 1'b0;
    forced   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_valid && cfg_ready) begin
          capture  = 1'b1;
          cnt_nx   = '0;
          state_nx = S_WAIT_BOUND;
        end
      end
      S_WAIT_BOUND: begin
        cnt_nx = cnt + CNT_W'(1);
        // A boundary strobe always wins over the timeout in the same cycle.
        if (rate_strobe) begin
          commit = 1'b1;
        end else if (cnt == TIMEOUT_LAST) begin
          commit = 1'b1;
          forced = 1'b1;
        end
        if (commit) begin
          cnt_nx   = '0;
          state_nx = disruptive ? S_FLUSH : S_IDLE;
        end
      end
      S_FLUSH: begin
        if (cnt == FLUSH_LAST) begin
          cnt_nx   = '0;
          state_nx = S_SETTLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_nx   = '0;
          state_nx = S_IDLE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = S_FLUSH;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_FLUSH;
      cnt          <= '0;
      sh_freq      <= '0;
      sh_dir       <= 1'b0;
      sh_ns_en     <= 1'b0;
      sh_iq_swap   <= 1'b0;
      sh_tuner_byp <= 1'b0;
      lo_freq      <= '0;
      lo_dir       <= 1'b0;
      lo_ns_en     <= 1'b0;
      iq_swap      <= 1'b0;
      tuner_byp    <= 1'b1;
      dp_reset     <= 1'b1;
      mute         <= 1'b1;
      busy         <= 1'b1;
      cfg_ready    <= 1'b0;
      timeout_flag <= 1'b0;
      apply_cnt    <= 8'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (capture) begin
        sh_freq      <= cfg_freq;
        sh_dir       <= cfg_dir;
        sh_ns_en     <= cfg_ns_en;
        sh_iq_swap   <= cfg_iq_swap;
        sh_tuner_byp <= cfg_tuner_byp;
      end
      if (commit) begin
        lo_freq   <= sh_freq;
        lo_dir    <= sh_dir;
        lo_ns_en  <= sh_ns_en;
        iq_swap   <= sh_iq_swap;
        tuner_byp <= sh_tuner_byp;
        apply_cnt <= apply_cnt + 8'd1;
      end
      if (forced) begin
        timeout_flag <= 1'b1;
      end
      cfg_ready <= (state_nx == S_IDLE);
      busy      <= (state_nx != S_IDLE);
      dp_reset  <= (state_nx == S_FLUSH);
      mute      <= (state_nx == S_FLUSH) || (state_nx == S_SETTLE);
    end
  end

endmodule

// File: tb/tb_qduc_ctrl.sv
// Bench for qduc_ctrl: directed scenarios plus randomized requests checked against a
// request-level model of the committed configuration and flush/mute timing.
module tb_qduc_ctrl;

  localparam int FSZ     = 31;
  localparam int FLUSH   = 128;
  localparam int SETTLE  = 256;
  localparam int TIMEOUT = 1024;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [FSZ-1:0] cfg_freq = '0;
  logic           cfg_dir = 1'b0;
  logic           cfg_ns_en = 1'b0;
  logic           cfg_iq_swap = 1'b0;
  logic           cfg_tuner_byp = 1'b0;
  logic           rate_strobe = 1'b0;
  logic [FSZ-1:0] lo_freq;
  logic           lo_dir, lo_ns_en, iq_swap, tuner_byp;
  logic           dp_reset, mute, busy, timeout_flag;
  logic [7:0]     apply_cnt;

  int checks = 0;
  int errors = 0;

  // Model of the committed configuration
  logic [FSZ-1:0] m_freq;
  logic           m_dir, m_ns, m_iq, m_byp, m_tflag;
  logic [7:0]     m_apply;

  logic [FSZ+3:0] dut_cfg;
  assign dut_cfg = {lo_freq, lo_dir, lo_ns_en, iq_swap, tuner_byp};

  qduc_ctrl #(
    .FSZ(FSZ), .CNT_W(16), .FLUSH_CYCLES(FLUSH), .SETTLE_CYCLES(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_freq(cfg_freq), .cfg_dir(cfg_dir), .cfg_ns_en(cfg_ns_en),
    .cfg_iq_swap(cfg_iq_swap), .cfg_tuner_byp(cfg_tuner_byp), .rate_strobe(rate_strobe),
    .lo_freq(lo_freq), .lo_dir(lo_dir), .lo_ns_en(lo_ns_en), .iq_swap(iq_swap),
    .tuner_byp(tuner_byp), .dp_reset(dp_reset), .mute(mute), .busy(busy),
    .timeout_flag(timeout_flag), .apply_cnt(apply_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #900us;
    $display("FAIL watchdog: simulation still running at 900us, required to finish earlier");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [FSZ+3:0] exp_cfg();
    return {m_freq, m_dir, m_ns, m_iq, m_byp};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_freq = '0; m_dir = 1'b0; m_ns = 1'b0; m_iq = 1'b0; m_byp = 1'b1;
    m_tflag = 1'b0; m_apply = 8'd0;
  endtask

  task automatic model_commit(input logic [FSZ-1:0] f, input logic d, input logic ns,
                              input logic iq, input logic byp, input bit forced,
                              output bit disr);
    disr = (byp != m_byp) || (d != m_dir);
    m_freq = f; m_dir = d; m_ns = ns; m_iq = iq; m_byp = byp;
    m_apply = m_apply + 8'd1;
    if (forced) m_tflag = 1'b1;
  endtask

  // Waits (bounded) for cfg_ready, presents one request for the acceptance cycle, and
  // returns in the first cycle after acceptance.
  task automatic accept_req(input logic [FSZ-1:0] f, input logic d, input logic ns,
                            input logic iq, input logic byp, input logic strobe_now);
    int n;
    n = 0;
    while (cfg_ready !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: cfg_ready=%b, required 1 within 2000 cycles", cfg_ready);
    end
    cfg_freq = f; cfg_dir = d; cfg_ns_en = ns; cfg_iq_swap = iq; cfg_tuner_byp = byp;
    cfg_valid = 1'b1;
    rate_strobe = strobe_now;
    tick();
    cfg_valid = 1'b0;
    rate_strobe = 1'b0;
  endtask

  // Counts dp_reset and mute cycles from the current cycle until busy drops.
  task automatic measure_busy(input bit noise, output int dp_n, output int mute_n);
    int n;
    n = 0; dp_n = 0; mute_n = 0;
    while (busy === 1'b1 && n < 5000) begin
      dp_n += int'(dp_reset);
      mute_n += int'(mute);
      rate_strobe = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      n++;
    end
    rate_strobe = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_wait: busy=%b, required 0 within 5000 cycles", busy);
    end
  endtask

  task automatic test_reset();
    int dp_n, mute_n;
    reset = 1'b0; cfg_valid = 1'b0; rate_strobe = 1'b0;
    tick();
    tick();
    model_reset();
    checks++; if ({dp_reset, mute, busy, cfg_ready} !== 4'b1110) begin errors++; $display("FAIL reset_status: dp/mute/busy/ready=%b required 1110", {dp_reset, mute, busy, cfg_ready}); end
    checks++; if (dut_cfg !== exp_cfg()) begin errors++; $display("FAIL reset_cfg: got %h required %h", dut_cfg, exp_cfg()); end
    checks++; if ({apply_cnt, timeout_flag} !== 9'd0) begin errors++; $display("FAIL reset_counters: apply=%0d flag=%b required 0/0", apply_cnt, timeout_flag); end
    reset = 1'b1;
    measure_busy(1'b0, dp_n, mute_n);
    checks++; if (dp_n != FLUSH) begin errors++; $display("FAIL reset_flush_len: got %0d required %0d", dp_n, FLUSH); end
    checks++; if (mute_n != FLUSH + SETTLE) begin errors++; $display("FAIL reset_mute_len: got %0d required %0d", mute_n, FLUSH + SETTLE); end
    checks++; if ({cfg_ready, dp_reset, mute} !== 3'b100) begin errors++; $display("FAIL reset_idle: ready/dp/mute=%b required 100", {cfg_ready, dp_reset, mute}); end
    checks++; if (dut_cfg !== exp_cfg()) begin errors++; $display("FAIL reset_idle_cfg: got %h required %h", dut_cfg, exp_cfg()); end
  endtask

  task automatic test_normal_commit();
    logic [FSZ-1:0] f;
    bit disr;
    logic saw;
    f = 31'h12345678;
    accept_req(f, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL normal_ready_drop: got %b required 0", cfg_ready); end
    saw = 1'b0;
    repeat (9) begin
      saw = saw | dp_reset | mute;
      tick();
    end
    checks++; if (dut_cfg !== exp_cfg()) begin errors++; $display("FAIL normal_precommit: got %h required %h", dut_cfg, exp_cfg()); end
    rate_strobe = 1'b1;
    tick();
    rate_strobe = 1'b0;
    model_commit(f, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, disr);
    saw = saw | dp_reset | mute;
    checks++; if (dut_cfg !== exp_cfg()) begin errors++; $display("FAIL normal_commit_cfg: got %h required %h", dut_cfg, exp_cfg()); end
    checks++; if (apply_cnt !== 8'd1) begin errors++; $display("FAIL normal_apply: got %0d required 1", apply_cnt); end
    checks++; if ({cfg_ready, busy, saw} !== 3'b100) begin errors++; $display("FAIL normal_status: ready/busy/pulse=%b required 100", {cfg_ready, busy, saw}); end
  endtask

  task automatic test_disruptive();
    logic [FSZ-1:0] f;
    logic ns, iq;
    bit disr;
    int d, dp_n, mute_n;
    f = FSZ'($urandom()); ns = 1'($urandom_range(0, 1)); iq = 1'($urandom_range(0, 1));
    d = $urandom_range(1, 20);
    accept_req(f, m_dir, ns, iq, 1'b0, 1'b0);
    repeat (d - 1) tick();
    rate_strobe = 1'b1;
    tick();
    rate_strobe = 1'b0;
    model_commit(f, m_dir, ns, iq, 1'b0, 1'b0, disr);
    checks++; if (dut_cfg !== exp_cfg()) begin errors++; $display("FAIL disr_cfg: got %h required %h", dut_cfg, exp_cfg()); end
    checks++; if ({dp_reset, mute, cfg_ready} !== 3'b110) begin errors++; $display("FAIL disr_status: dp/mute/ready=%b required 110", {dp_reset, mute, cfg_ready}); end
    checks++; if (apply_cnt !== m_apply) begin errors++; $display("FAIL disr_apply: got %0d required %0d", apply_cnt, m_apply); end
    measure_busy(1'b1, dp_n, mute_n);
    checks++; if (dp_n != FLUSH) begin errors++; $display("FAIL disr_flush_len: got %0d required %0d", dp_n, FLUSH); end
    checks++; if (mute_n != FLUSH + SETTLE) begin errors++; $display("FAIL disr_mute_len: got %0d required %0d", mute_n, FLUSH + SETTLE); end
    checks++; if (dut_cfg !== exp_cfg()) begin errors++; $display("FAIL disr_cfg_after: got %h required %h", dut_cfg, exp_cfg()); end
  endtask

  task automatic test_strobe_at_limit();
    logic [FSZ-1:0] f;
    bit disr;
    f = m_freq ^ 31'h0000_0F0F;
    accept_req(f, m_dir, m_ns, m_iq, m_byp, 1'b0);
    repeat (TIMEOUT - 1) tick();
    checks++; if (dut_cfg !== exp_cfg()) begin errors++; $display("FAIL limit_precommit: got %h required %h", dut_cfg, exp_cfg()); end
    rate_strobe = 1'b1;
    tick();
    rate_strobe = 1'b0;
    model_commit(f, m_dir, m_ns, m_iq, m_byp, 1'b0, disr);
    checks++; if (dut_cfg !== exp_cfg()) begin errors++; $display("FAIL limit_cfg: got %h required %h", dut_cfg, exp_cfg()); end
    checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL limit_flag: got %b required 0", timeout_flag); end
  endtask

  task automatic test_timeout();
    logic [FSZ-1:0] f;
    bit disr;
    f = m_freq ^ 31'h5555_0001;
    accept_req(f, m_dir, m_ns, m_iq, m_byp, 1'b0);
    repeat (TIMEOUT - 1) tick();
    checks++; if ({dut_cfg, timeout_flag} !== {exp_cfg(), 1'b0}) begin errors++; $display("FAIL timeout_early: cfg/flag=%h required %h", {dut_cfg, timeout_flag}, {exp_cfg(), 1'b0}); end
    tick();
    model_commit(f, m_dir, m_ns, m_iq, m_byp, 1'b1, disr);
    checks++; if (dut_cfg !== exp_cfg()) begin errors++; $display("FAIL timeout_cfg: got %h required %h", dut_cfg, exp_cfg()); end
    checks++; if ({timeout_flag, apply_cnt} !== {m_tflag, m_apply}) begin errors++; $display("FAIL timeout_flag: flag/apply=%h required %h", {timeout_flag, apply_cnt}, {m_tflag, m_apply}); end
    f = FSZ'($urandom());
    accept_req(f, m_dir, m_ns, m_iq, m_byp, 1'b0);
    rate_strobe = 1'b1;
    tick();
    rate_strobe = 1'b0;
    model_commit(f, m_dir, m_ns, m_iq, m_byp, 1'b0, disr);
    checks++; if ({dut_cfg, timeout_flag} !== {exp_cfg(), 1'b1}) begin errors++; $display("FAIL timeout_sticky: cfg/flag=%h required %h", {dut_cfg, timeout_flag}, {exp_cfg(), 1'b1}); end
  endtask

  task automatic test_strobe_in_accept();
    logic [FSZ-1:0] f1, f2;
    bit disr;
    logic ready_seen;
    int d;
    f1 = m_freq ^ 31'h0ABC_0000;
    f2 = f1 ^ 31'h0000_1234;
    cfg_freq = f1; cfg_dir = m_dir; cfg_ns_en = m_ns; cfg_iq_swap = m_iq; cfg_tuner_byp = m_byp;
    cfg_valid = 1'b1;
    rate_strobe = 1'b1;
    tick();
    rate_strobe = 1'b0;
    cfg_freq = f2;
    ready_seen = 1'b0;
    repeat (127) begin
      ready_seen = ready_seen | cfg_ready;
      tick();
    end
    checks++; if (dut_cfg !== exp_cfg()) begin errors++; $display("FAIL accstrobe_ignored: got %h required %h", dut_cfg, exp_cfg()); end
    rate_strobe = 1'b1;
    tick();
    rate_strobe = 1'b0;
    model_commit(f1, m_dir, m_ns, m_iq, m_byp, 1'b0, disr);
    checks++; if (dut_cfg !== exp_cfg()) begin errors++; $display("FAIL accstrobe_first: got %h required %h", dut_cfg, exp_cfg()); end
    checks++; if ({ready_seen, cfg_ready} !== 2'b01) begin errors++; $display("FAIL accstrobe_ready: seen/ready=%b required 01", {ready_seen, cfg_ready}); end
    tick();
    cfg_valid = 1'b0;
    d = $urandom_range(1, 10);
    repeat (d - 1) tick();
    rate_strobe = 1'b1;
    tick();
    rate_strobe = 1'b0;
    model_commit(f2, m_dir, m_ns, m_iq, m_byp, 1'b0, disr);
    checks++; if (dut_cfg !== exp_cfg()) begin errors++; $display("FAIL accstrobe_second: got %h required %h", dut_cfg, exp_cfg()); end
  endtask

  task automatic test_random(input int iters);
    logic [FSZ-1:0] f;
    logic d, ns, iq, byp, s_acc;
    bit to, disr;
    int off, dp_n, mute_n;
    for (int i = 0; i < iters; i++) begin
      f = FSZ'($urandom()); d = 1'($urandom_range(0, 1)); ns = 1'($urandom_range(0, 1));
      iq = 1'($urandom_range(0, 1)); byp = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        f = m_freq; d = m_dir; ns = m_ns; iq = m_iq; byp = m_byp;
      end
      s_acc = 1'($urandom_range(0, 3) == 0);
      to = ($urandom_range(0, 19) == 0);
      off = to ? TIMEOUT : $urandom_range(1, 30);
      accept_req(f, d, ns, iq, byp, s_acc);
      repeat (off - 1) tick();
      checks++; if ({dut_cfg, cfg_ready} !== {exp_cfg(), 1'b0}) begin errors++; $display("FAIL rand_pre[%0d]: cfg/ready=%h required %h", i, {dut_cfg, cfg_ready}, {exp_cfg(), 1'b0}); end
      rate_strobe = !to;
      tick();
      rate_strobe = 1'b0;
      model_commit(f, d, ns, iq, byp, to, disr);
      checks++; if (dut_cfg !== exp_cfg()) begin errors++; $display("FAIL rand_cfg[%0d]: got %h required %h", i, dut_cfg, exp_cfg()); end
      checks++; if ({apply_cnt, timeout_flag} !== {m_apply, m_tflag}) begin errors++; $display("FAIL rand_cnt[%0d]: apply/flag=%h required %h", i, {apply_cnt, timeout_flag}, {m_apply, m_tflag}); end
      if (disr) begin
        checks++; if ({dp_reset, mute, cfg_ready} !== 3'b110) begin errors++; $display("FAIL rand_disr[%0d]: dp/mute/ready=%b required 110", i, {dp_reset, mute, cfg_ready}); end
        measure_busy(1'b1, dp_n, mute_n);
        checks++; if ({dp_n, mute_n} != {FLUSH, FLUSH + SETTLE}) begin errors++; $display("FAIL rand_flush[%0d]: dp=%0d mute=%0d required %0d/%0d", i, dp_n, mute_n, FLUSH, FLUSH + SETTLE); end
      end else begin
        checks++; if ({cfg_ready, busy, dp_reset, mute} !== 4'b1000) begin errors++; $display("FAIL rand_nondisr[%0d]: ready/busy/dp/mute=%b required 1000", i, {cfg_ready, busy, dp_reset, mute}); end
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    logic [FSZ-1:0] f;
    bit disr;
    int dp_n, mute_n;
    f = m_freq ^ 31'h7000_00FF;
    accept_req(f, ~m_dir, m_ns, m_iq, m_byp, 1'b0);
    tick();
    tick();
    rate_strobe = 1'b1;
    tick();
    rate_strobe = 1'b0;
    model_commit(f, ~m_dir, m_ns, m_iq, m_byp, 1'b0, disr);
    checks++; if ({dut_cfg, dp_reset} !== {exp_cfg(), 1'b1}) begin errors++; $display("FAIL midflush_commit: cfg/dp=%h required %h", {dut_cfg, dp_reset}, {exp_cfg(), 1'b1}); end
    repeat (20) tick();
    reset = 1'b0;
    tick();
    model_reset();
    checks++; if (dut_cfg !== exp_cfg()) begin errors++; $display("FAIL midflush_cfg: got %h required %h", dut_cfg, exp_cfg()); end
    checks++; if ({apply_cnt, timeout_flag} !== 9'd0) begin errors++; $display("FAIL midflush_counters: apply=%0d flag=%b required 0/0", apply_cnt, timeout_flag); end
    checks++; if ({dp_reset, mute, busy, cfg_ready} !== 4'b1110) begin errors++; $display("FAIL midflush_status: dp/mute/busy/ready=%b required 1110", {dp_reset, mute, busy, cfg_ready}); end
    reset = 1'b1;
    measure_busy(1'b0, dp_n, mute_n);
    checks++; if ({dp_n, mute_n} != {FLUSH, FLUSH + SETTLE}) begin errors++; $display("FAIL midflush_seq: dp=%0d mute=%0d required %0d/%0d", dp_n, mute_n, FLUSH, FLUSH + SETTLE); end
  endtask

  task automatic test_wrap();
    logic [FSZ-1:0] f;
    bit disr;
    for (int i = 0; i < 256; i++) begin
      f = FSZ'($urandom());
      accept_req(f, m_dir, m_ns, m_iq, m_byp, 1'b0);
      rate_strobe = 1'b1;
      tick();
      rate_strobe = 1'b0;
      model_commit(f, m_dir, m_ns, m_iq, m_byp, 1'b0, disr);
      if (i == 254) begin
        checks++; if (apply_cnt !== m_apply) begin errors++; $display("FAIL wrap_255: got %0d required %0d", apply_cnt, m_apply); end
      end
    end
    checks++; if (apply_cnt !== 8'd0) begin errors++; $display("FAIL wrap_zero: got %0d required 0", apply_cnt); end
    checks++; if (dut_cfg !== exp_cfg()) begin errors++; $display("FAIL wrap_cfg: got %h required %h", dut_cfg, exp_cfg()); end
  endtask

  initial begin
    test_reset();
    test_normal_commit();
    test_disruptive();
    test_strobe_at_limit();
    test_timeout();
    test_strobe_in_accept();
    test_random(30);
    test_reset_mid_flush();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qduc_ctrl.md
Name: qduc_ctrl

Overview:
- Configuration sequencer for the quadrature DUC.
- Accepts tuning/configuration requests over a valid/ready handshake and holds them in a shadow register.
- Commits each request atomically on a CIC stage-1 input-rate boundary.
- For disruptive changes (tuner bypass or LO direction toggling), runs a flush/mute sequence: datapath reset, then muted settle, before returning to idle.

Parameters:
- FSZ, 31, NCO tuning word width.
- CNT_W, 16, width of the internal sequencing counter.
- FLUSH_CYCLES, 128, clk cycles the datapath reset is held during a flush (1..2^CNT_W-1).
- SETTLE_CYCLES, 256, clk cycles mute stays asserted after the flush ends (1..2^CNT_W-1).
- TIMEOUT, 1024, max clk cycles to wait for a rate boundary before a forced commit (1..2^CNT_W-1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-low; reset == 0 resets on the rising edge of clk.
- cfg_valid  in  1  request valid.
- cfg_ready  out  1  request accepted when cfg_valid & cfg_ready.
- cfg_freq  in  FSZ  requested NCO tuning word.
- cfg_dir  in  1  requested NCO direction.
- cfg_ns_en  in  1  requested noise-shaping enable.
- cfg_iq_swap  in  1  requested IQ swap.
- cfg_tuner_byp  in  1  requested tuner bypass.
- rate_strobe  in  1  one-cycle pulse at the CIC stage-1 input-rate boundary (clk/128).
- lo_freq  out  FSZ  committed tuning word.
- lo_dir  out  1  committed direction.
- lo_ns_en  out  1  committed noise-shaping enable.
- iq_swap  out  1  committed IQ swap.
- tuner_byp  out  1  committed tuner bypass.
- dp_reset  out  1  active-high reset to the DUC datapath.
- mute  out  1  output-mute request to the DAC interface.
- busy  out  1  high in every state except IDLE.
- timeout_flag  out  1  sticky; set on any forced commit, cleared only by reset.
- apply_cnt  out  8  count of committed requests, wraps 255->0.

Behaviour:
- All outputs are registered.
- Reset values: lo_freq=0, lo_dir=0, lo_ns_en=0, iq_swap=0, tuner_byp=1, dp_reset=1, mute=1, busy=1, cfg_ready=0, timeout_flag=0, apply_cnt=0, shadow=0, state=FLUSH, counter=0.
- After reset is released, the block runs FLUSH then SETTLE with the reset-value configuration, then enters IDLE.
- States: IDLE, WAIT_BOUND, FLUSH, SETTLE.
- IDLE:
  - cfg_ready=1, busy=0, dp_reset=0, mute=0.
  - On cfg_valid, capture cfg_* into the shadow register, clear the counter, go to WAIT_BOUND.
  - cfg_ready drops the cycle after acceptance.
- WAIT_BOUND:
  - cfg_ready=0; the counter increments each cycle.
  - rate_strobe is sampled only from the cycle after acceptance; a strobe coincident with the acceptance cycle is ignored.
  - Strobe high at cycle M: commit, so outputs show the shadow values at M+1.
  - No strobe and counter reaches TIMEOUT-1: forced commit on the next edge and timeout_flag set. A strobe in that same cycle counts as a normal commit; timeout_flag is not set.
- Commit:
  - Update all five config outputs together and increment apply_cnt.
  - Disruptive when shadow tuner_byp != current tuner_byp, or shadow dir != current lo_dir.
  - Non-disruptive commit returns to IDLE, so cfg_ready=1 at M+1.
  - Disruptive commit goes to FLUSH with dp_reset=1 and mute=1 asserted in the same cycle the outputs change (M+1).
  - A request identical to the current configuration is a normal non-disruptive commit and is still counted.
- FLUSH: dp_reset=1, mute=1 for exactly FLUSH_CYCLES cycles, then SETTLE with the counter cleared.
- SETTLE: dp_reset=0, mute=1 for exactly SETTLE_CYCLES cycles, then IDLE (mute=0, cfg_ready=1).
- rate_strobe is ignored outside WAIT_BOUND.
- cfg_* inputs are ignored when cfg_ready=0; upstream must hold cfg_valid and data stable until accepted.
- Reset asserted in any state aborts the operation and discards the shadow register; the block takes the reset values on the next edge.
- Throughput: at most one request is in flight; there is no queueing.

Test Plan:
- Release reset, hold cfg_valid=0 -> dp_reset=1 for 128 cycles, mute=1 for 384 cycles total, then busy=0, cfg_ready=1, tuner_byp=1, lo_freq=0.
- From idle with tuner_byp=1, request freq=0x12345678, byp=1, dir=0; strobe 10 cycles later -> lo_freq updates exactly one cycle after the strobe; no dp_reset or mute pulse; apply_cnt=1; cfg_ready back high that same cycle.
- Request byp=0 -> at commit, tuner_byp=0, dp_reset=1 for 128 cycles, mute=1 for 384 cycles, then IDLE; apply_cnt increments by 1.
- Request with rate_strobe held at 0 -> forced commit after 1024 cycles in WAIT_BOUND; timeout_flag=1 and stays 1 across later normal commits until reset.
- cfg_valid high with strobe in the acceptance cycle, next strobe 128 cycles later -> commit follows the second strobe; cfg_valid held high while busy -> no second capture until cfg_ready=1.
- Assert reset=0 mid-FLUSH after a freq change -> next cycle lo_freq=0, tuner_byp=1, apply_cnt=0, state FLUSH; 256 sequential commits -> apply_cnt wraps to 0.
